alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command-side initiator for the 16-bit combinational ALU. Accepts operation commands over a valid/ready stream and buffers them in a small FIFO. Issues each command to the ALU one at a time, captures the ALU result, and returns it on a valid/ready response stream. Illegal opcodes and divide-by-zero are screened out and never reach the ALU.

## Interface
- DATA_W, 16, operand/result width; ALU-facing ports use the same width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- iClk  in  1  sole clock; all state updates on the rising edge.
- iRst  in  1  one clock; reset is synchronous and active-high.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  FIFO can accept a command.
- iCmdOp  in  4  opcode. 0 AND, 1 OR, 2 ADD, 3 NOR, 4 EQ, 5 SUB, 6 LT, 7 MUL, 8 DIV.
- iCmdA, iCmdB  in  DATA_W  operands.
- oAluA, oAluB  out  DATA_W  registered operands to the ALU.
- oAluCtrl  out  4  registered opcode to the ALU.
- iAluOut  in  DATA_W  ALU result.
- iAluCarry  in  1  ALU carry.
- oRspValid  out  1  response present.
- iRspReady  in  1  consumer accepts the response.
- oRspData  out  DATA_W  result.
- oRspCarry  out  1  carry; meaningful for ADD only.
- oRspZero  out  1  result equals zero.
- oRspErr  out  1  command rejected (illegal opcode or divide-by-zero).
- oRspOp  out  4  opcode of the command that produced this response.
- oBusy  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- Push:
  - A command is pushed when iCmdValid && oCmdReady.
  - oCmdReady = !full && !iRst. It does not look ahead at a same-cycle pop.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the command register.
    - Legal opcode (0-8) with no divide-by-zero: load oAluA, oAluB, oAluCtrl and go to ISSUE.
    - Opcode 9-15: go to RESP with oRspErr=1 and oRspData=0. ALU outputs are left unchanged.
    - Opcode 8 with B==0: go to RESP with oRspErr=1 and oRspData={DATA_W{1'b1}}. ALU outputs are left unchanged.
  - ISSUE: ALU inputs are stable for one full cycle. At the end of the cycle:
    - oRspData <= iAluOut.
    - oRspCarry <= (op==2) ? iAluCarry : 0.
    - oRspZero <= (iAluOut==0).
    - oRspErr <= 0.
    - Go to RESP.
  - RESP: oRspValid=1. All oRsp* fields are held stable until iRspReady; on the handshake go to IDLE.
- The ALU's own zero flag is not used; oRspZero is always computed locally from the captured data.
- Responses are returned strictly in command order. Only one command is in flight at a time.
- oAluA, oAluB and oAluCtrl hold their last issued values between commands.

## Timing
- Reset values (cycle after iRst is sampled high):
  - FIFO empty, FSM in IDLE.
  - oRspValid=0 and all oRsp* fields 0.
  - oAluA=0, oAluB=0, oAluCtrl=0.
  - oBusy=0.
  - oCmdReady=0 while iRst is high, and 1 on the first cycle after it drops.
- Reset mid-operation: the FIFO contents and any in-flight command are discarded; no response is produced for them.
- Latency for a legal command pushed at edge N into an empty FIFO with the FSM in IDLE:
  - pop at edge N+1;
  - ISSUE during cycle N+1..N+2;
  - oRspValid high from edge N+2.
- Error commands skip ISSUE, so oRspValid is high from edge N+1.
- Throughput: with iRspReady held high, one legal result every 3 cycles and one error response every 2 cycles.
- FIFO full: oCmdReady=0 even if a pop occurs in the same cycle. A held iCmdValid is accepted on the next cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, and use a separate occupancy count (0..FIFO_DEPTH).
- A push into an empty FIFO is not visible to the FSM until the following cycle; there is no bypass.
- Backpressure: if iRspReady stays low, the FSM stays in RESP. The FIFO keeps filling until full, then oCmdReady drops.

## Test plan
- Reset, then push ADD A=16'hFFFF B=16'h0001 at edge N with iRspReady=1 -> oAluCtrl=2 after edge N+1; oRspValid at N+2 with data 16'h0000, carry 1, zero 1, err 0.
- Push opcode 4'hC -> oRspValid one edge after the pop with err 1 and data 0; oAluCtrl keeps its previous value.
- Push DIV A=100 B=0 -> response with err 1 and data 16'hFFFF. Then push DIV A=100 B=7 -> response data equals the ALU output (14), err 0.
- Hold iRspReady=0 and push 6 commands back-to-back -> 1 command held in RESP plus 4 in the FIFO; oCmdReady falls after the 5th accepted push. Release iRspReady -> all 5 responses arrive in order with matching oRspOp. The 6th push is accepted once the first pop frees a slot.
- Assert iRst while in ISSUE with 3 commands queued -> the next cycle shows oRspValid=0, oBusy=0, oAlu*=0, and no stale responses afterward.
- Stream 8 SUB commands with iRspReady=1 -> oRspValid pulses every 3 cycles; the FIFO pointers wrap through index 0 with no lost or duplicated commands.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to an external
// combinational ALU, and returns each captured result on a valid/ready stream.
module alu_cmd_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic [3:0]        iCmdOp,
  input  logic [DATA_W-1:0] iCmdA,
  input  logic [DATA_W-1:0] iCmdB,
  output logic [DATA_W-1:0] oAluA,
  output logic [DATA_W-1:0] oAluB,
  output logic [3:0]        oAluCtrl,
  input  logic [DATA_W-1:0] iAluOut,
  input  logic              iAluCarry,
  output logic              oRspValid,
  input  logic              iRspReady,
  output logic [DATA_W-1:0] oRspData,
  output logic              oRspCarry,
  output logic              oRspZero,
  output logic              oRspErr,
  output logic [3:0]        oRspOp,
  output logic              oBusy
);

  // state  | meaning
  // IDLE   | waiting for a queued command; pops and screens the FIFO head
  // ISSUE  | ALU inputs stable this cycle; result captured at its end
  // RESP   | response presented until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  state_e state_q, state_d;

  logic [3:0]        fifo_op_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_a_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_b_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;

  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [3:0]        alu_ctrl_q, rsp_op_q;
  logic              rsp_carry_q, rsp_zero_q, rsp_err_q;

  logic              full, empty, push, pop;
  logic [3:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;
  logic              head_illegal, head_div0;

  assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = iCmdValid && oCmdReady;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign head_op = fifo_op_q[rd_ptr_q];
  assign head_a  = fifo_a_q[rd_ptr_q];
  assign head_b  = fifo_b_q[rd_ptr_q];
  assign head_illegal = (head_op > 4'd8);
  assign head_div0    = (head_op == 4'd8) && (head_b == '0);

  always_ff @(posedge iClk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q] <= iCmdOp;
      fifo_a_q[wr_ptr_q]  <= iCmdA;
      fifo_b_q[wr_ptr_q]  <= iCmdB;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = (head_illegal || head_div0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  if (iRspReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oRspValid = (state_q == S_RESP);
    oBusy     = !empty || (state_q != S_IDLE);
    oCmdReady = !full && !iRst;
  end

  // Rejected commands bypass the ALU, so its inputs keep their last issued values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_op_q    <= '0;
    end else if (pop) begin
      rsp_op_q <= head_op;
      if (head_illegal) begin
        rsp_data_q  <= '0;
        rsp_carry_q <= 1'b0;
        rsp_zero_q  <= 1'b1;
        rsp_err_q   <= 1'b1;
      end else if (head_div0) begin
        rsp_data_q  <= '1;
        rsp_carry_q <= 1'b0;
        rsp_zero_q  <= 1'b0;
        rsp_err_q   <= 1'b1;
      end else begin
        alu_a_q    <= head_a;
        alu_b_q    <= head_b;
        alu_ctrl_q <= head_op;
      end
    end else if (state_q == S_ISSUE) begin
      rsp_data_q  <= iAluOut;
      rsp_carry_q <= (alu_ctrl_q == 4'd2) ? iAluCarry : 1'b0;
      rsp_zero_q  <= (iAluOut == '0);
      rsp_err_q   <= 1'b0;
    end
  end

  assign oAluA     = alu_a_q;
  assign oAluB     = alu_b_q;
  assign oAluCtrl  = alu_ctrl_q;
  assign oRspData  = rsp_data_q;
  assign oRspCarry = rsp_carry_q;
  assign oRspZero  = rsp_zero_q;
  assign oRspErr   = rsp_err_q;
  assign oRspOp    = rsp_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: models the ALU, scoreboards responses
// against commands accepted, and checks latency, backpressure and reset.
module tb_alu_cmd_sequencer;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [3:0]  iCmdOp;
  logic [15:0] iCmdA, iCmdB;
  logic [15:0] oAluA, oAluB;
  logic [3:0]  oAluCtrl;
  logic [15:0] iAluOut;
  logic        iAluCarry;
  logic        oRspValid;
  logic        iRspReady;
  logic [15:0] oRspData;
  logic        oRspCarry, oRspZero, oRspErr;
  logic [3:0]  oRspOp;
  logic        oBusy;

  always #5 iClk = ~iClk;

  alu_cmd_sequencer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdOp(iCmdOp),
    .iCmdA(iCmdA), .iCmdB(iCmdB),
    .oAluA(oAluA), .oAluB(oAluB), .oAluCtrl(oAluCtrl),
    .iAluOut(iAluOut), .iAluCarry(iAluCarry),
    .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData),
    .oRspCarry(oRspCarry), .oRspZero(oRspZero), .oRspErr(oRspErr),
    .oRspOp(oRspOp), .oBusy(oBusy)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   last_hs = -1;
  bit   stream_mode = 1'b0;

  // Reference ALU: {carry/borrow, result}
  function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [16:0] r;
    r = '0;
    case (op)
      4'd0: r = {1'b0, a & b};
      4'd1: r = {1'b0, a | b};
      4'd2: r = {1'b0, a} + {1'b0, b};
      4'd3: r = {1'b0, ~(a | b)};
      4'd4: r = {16'd0, a == b};
      4'd5: r = {1'b0, a} - {1'b0, b};
      4'd6: r = {16'd0, a < b};
      4'd7: begin p = 32'(a) * 32'(b); r = {1'b0, p[15:0]}; end
      4'd8: r = (b == 16'd0) ? 17'h0FFFF : {1'b0, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic rsp_t exp_rsp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t r;
    logic [16:0] res;
    r.op = op;
    if (op > 4'd8) begin
      r.data = 16'h0000; r.carry = 1'b0; r.zero = 1'b1; r.err = 1'b1;
    end else if (op == 4'd8 && b == 16'd0) begin
      r.data = 16'hFFFF; r.carry = 1'b0; r.zero = 1'b0; r.err = 1'b1;
    end else begin
      res = alu_model(op, a, b);
      r.data  = res[15:0];
      r.carry = (op == 4'd2) ? res[16] : 1'b0;
      r.zero  = (res[15:0] == 16'd0);
      r.err   = 1'b0;
    end
    return r;
  endfunction

  logic [16:0] alu_res;
  assign alu_res   = alu_model(oAluCtrl, oAluA, oAluB);
  assign iAluOut   = alu_res[15:0];
  assign iAluCarry = alu_res[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on response handshake, push on command handshake.
  always @(negedge iClk) begin
    rsp_t e;
    cyc++;
    if (oRspValid === 1'b1 && iRspReady === 1'b1) begin
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_op",    32'(oRspOp),    32'(e.op));
        check("rsp_data",  32'(oRspData),  32'(e.data));
        check("rsp_carry", 32'(oRspCarry), 32'(e.carry));
        check("rsp_zero",  32'(oRspZero),  32'(e.zero));
        check("rsp_err",   32'(oRspErr),   32'(e.err));
      end
      rsp_count++;
      if (stream_mode) begin
        if (last_hs >= 0) check("stream_interval", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
      end
    end
    if (iRst === 1'b0 && iCmdValid === 1'b1 && oCmdReady === 1'b1)
      exp_q.push_back(exp_rsp(iCmdOp, iCmdA, iCmdB));
  end

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    iCmdOp = op; iCmdA = a; iCmdB = b; iCmdValid = 1'b1;
    @(negedge iClk);
    while (oCmdReady !== 1'b1 && n < 100) begin
      @(negedge iClk);
      n++;
    end
    check("push_accept", 32'(oCmdReady), 32'd1);
    @(posedge iClk); #1;
    iCmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge iClk);
    while (oBusy !== 1'b0 && n < 300) begin
      @(negedge iClk);
      n++;
    end
    check("idle_reached", 32'(oBusy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    @(posedge iClk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    iRst = 1'b1; iCmdValid = 1'b0; iCmdOp = '0; iCmdA = '0; iCmdB = '0; iRspReady = 1'b0;

    // Reset state
    repeat (2) @(posedge iClk);
    #1;
    check("rst_cmd_ready", 32'(oCmdReady), 32'd0);
    check("rst_rsp_valid", 32'(oRspValid), 32'd0);
    check("rst_busy",      32'(oBusy),     32'd0);
    check("rst_alu_a",     32'(oAluA),     32'd0);
    check("rst_alu_b",     32'(oAluB),     32'd0);
    check("rst_alu_ctrl",  32'(oAluCtrl),  32'd0);
    check("rst_rsp_fields", {11'd0, oRspData, oRspCarry, oRspZero, oRspErr, oRspOp}, 32'd0);
    iRst = 1'b0; iRspReady = 1'b1;
    @(negedge iClk);
    check("post_rst_ready", 32'(oCmdReady), 32'd1);
    @(posedge iClk); #1;

    // ADD with carry out: issue at N+1, response at N+2
    push(4'd2, 16'hFFFF, 16'h0001);
    check("add_rsp_not_yet", 32'(oRspValid), 32'd0);
    @(posedge iClk); #1;
    check("add_alu_ctrl", 32'(oAluCtrl),  32'd2);
    check("add_alu_a",    32'(oAluA),     32'hFFFF);
    check("add_alu_b",    32'(oAluB),     32'h0001);
    check("add_issue_nv", 32'(oRspValid), 32'd0);
    @(posedge iClk); #1;
    check("add_rsp_valid", 32'(oRspValid), 32'd1);
    wait_idle();

    // Illegal opcode: response one edge after pop, ALU untouched
    push(4'hC, 16'h1234, 16'h5678);
    @(posedge iClk); #1;
    check("ill_rsp_valid", 32'(oRspValid), 32'd1);
    check("ill_rsp_err",   32'(oRspErr),   32'd1);
    check("ill_rsp_data",  32'(oRspData),  32'd0);
    check("ill_alu_ctrl",  32'(oAluCtrl),  32'd2);
    check("ill_alu_a",     32'(oAluA),     32'hFFFF);
    wait_idle();

    // Divide by zero, then a legal divide
    push(4'd8, 16'd100, 16'd0);
    @(posedge iClk); #1;
    check("div0_rsp_valid", 32'(oRspValid), 32'd1);
    check("div0_data",      32'(oRspData),  32'hFFFF);
    wait_idle();
    push(4'd8, 16'd100, 16'd7);
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    check("div_rsp_valid", 32'(oRspValid), 32'd1);
    check("div_data",      32'(oRspData),  32'd14);
    check("div_err",       32'(oRspErr),   32'd0);
    wait_idle();

    // Backpressure: 1 held in RESP + 4 queued, 6th waits for a free slot
    iRspReady = 1'b0;
    push(4'd0, 16'hF0F0, 16'h0FF0);
    push(4'd1, 16'hF000, 16'h000F);
    push(4'd3, 16'h00FF, 16'h0F00);
    push(4'd4, 16'hABCD, 16'hABCD);
    push(4'd6, 16'd3,    16'd9);
    @(negedge iClk);
    check("bp_ready_low", 32'(oCmdReady), 32'd0);
    check("bp_rsp_valid", 32'(oRspValid), 32'd1);
    check("bp_rsp_op",    32'(oRspOp),    32'd0);
    @(posedge iClk); #1;
    iCmdOp = 4'd7; iCmdA = 16'd300; iCmdB = 16'd300; iCmdValid = 1'b1;
    repeat (2) begin
      @(negedge iClk);
      check("bp_hold_full", 32'(oCmdReady), 32'd0);
    end
    @(posedge iClk); #1;
    iRspReady = 1'b1;
    n = 0;
    @(negedge iClk);
    while (oCmdReady !== 1'b1 && n < 20) begin
      @(negedge iClk);
      n++;
    end
    check("bp_push6_delay", 32'(n), 32'd2);
    @(posedge iClk); #1;
    iCmdValid = 1'b0;
    wait_idle();

    // Reset while in ISSUE with 3 commands still queued
    iRspReady = 1'b0;
    push(4'd2, 16'd1, 16'd2);
    push(4'd2, 16'd3, 16'd4);
    push(4'd2, 16'd5, 16'd6);
    push(4'd2, 16'd7, 16'd8);
    push(4'd2, 16'd9, 16'd10);
    iRspReady = 1'b1;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    check("rst_mid_in_issue", {30'd0, oRspValid, oBusy}, 32'd1);
    check("rst_mid_alu_ctrl", 32'(oAluCtrl), 32'd2);
    check("rst_mid_alu_a",    32'(oAluA),    32'd3);
    iRst = 1'b1;
    exp_q.delete();
    snap = rsp_count;
    @(posedge iClk); #1;
    check("rst_mid_rsp_valid", 32'(oRspValid), 32'd0);
    check("rst_mid_busy",      32'(oBusy),     32'd0);
    check("rst_mid_alu",       {oAluA, oAluB}, 32'd0);
    check("rst_mid_ctrl",      32'(oAluCtrl),  32'd0);
    check("rst_mid_ready",     32'(oCmdReady), 32'd0);
    iRst = 1'b0;
    repeat (10) @(posedge iClk);
    #1;
    check("rst_no_stale", 32'(rsp_count - snap), 32'd0);
    check("rst_stay_idle", 32'(oBusy), 32'd0);

    // Stream 8 SUBs: one response every 3 cycles, pointers wrap twice
    wait_idle();
    snap = rsp_count;
    last_hs = -1;
    stream_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      push(4'd5, 16'(i * 1000), 16'd3000);
    wait_idle();
    stream_mode = 1'b0;
    check("stream_count", 32'(rsp_count - snap), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
